// File: rtl/soc_uart_pkg.sv
// Shared constants for the buffered SoC UART: register offsets, STATUS/IRQEN
// bit positions, minimum bit period and serial frame state encodings.
package soc_uart_pkg;

   // Register offsets inside the 16-byte window
   localparam logic [3:0] OFF_DIV    = 4'h0;
   localparam logic [3:0] OFF_DATA   = 4'h4;
   localparam logic [3:0] OFF_STATUS = 4'h8;
   localparam logic [3:0] OFF_IRQEN  = 4'hC;

   // STATUS bit indices
   localparam int unsigned ST_TX_FULL    = 0;
   localparam int unsigned ST_TX_IDLE    = 1;
   localparam int unsigned ST_RX_VALID   = 2;
   localparam int unsigned ST_RX_OVERRUN = 3;
   localparam int unsigned ST_FRAME_ERR  = 4;

   // IRQEN bit indices
   localparam int unsigned IE_RX_VALID = 0;
   localparam int unsigned IE_TX_IDLE  = 1;
   localparam int unsigned IE_ERR      = 2;

   // Shortest bit period the shifters will run at
   localparam logic [31:0] MIN_DIV = 32'd4;

   // Serial frame states, shared by the TX and RX shifters
   localparam logic [1:0] FS_IDLE  = 2'd0;
   localparam logic [1:0] FS_START = 2'd1;
   localparam logic [1:0] FS_DATA  = 2'd2;
   localparam logic [1:0] FS_STOP  = 2'd3;

   // Bit period actually used for a frame
   function automatic logic [31:0] eff_div(input logic [31:0] div);
      return (div < MIN_DIV) ? MIN_DIV : div;
   endfunction

endpackage

// File: rtl/soc_fifo_sync.sv
// Single-clock FIFO with occupancy count. DEPTH must be a power of two so the
// pointers wrap naturally. Push when full and pop when empty are ignored.
module soc_fifo_sync #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem[rptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage array, no reset needed since reads are gated by the count
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= wdata;
   end

   // Pointers and occupancy; simultaneous push and pop leave the count unchanged
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/soc_uart_fifo.sv
// Buffered UART on the picorv32 native memory bus: DIV/DATA/STATUS/IRQEN
// registers, TX and RX FIFOs, 8N1 shifters and sticky error flags.
// Optional feature: define SOC_UART_IRQ_EN to implement IRQEN and the irq output.
module soc_uart_fifo
   import soc_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0010,
   parameter int unsigned TX_DEPTH  = 16,
   parameter int unsigned RX_DEPTH  = 16,
   parameter logic [31:0] DIV_RESET = 32'd104
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        uart_tx,
   input  logic        uart_rx,
   output logic        irq
);

   localparam int unsigned TX_AW = $clog2(TX_DEPTH);
   localparam int unsigned RX_AW = $clog2(RX_DEPTH);

   // Bus side
   logic        sel, is_wr, tx_stall, acc;
   logic [3:0]  off;
   logic        wr_div, tx_push, rx_pop, w1c;
   logic        ready_q;
   logic [31:0] rdata_q, rd_val, status, irqen_rd, div_q;
   logic        overrun_q, frame_err_q;

   // FIFO side
   logic             tx_full, tx_empty, rx_full, rx_empty;
   logic [7:0]       tx_rdata, rx_rdata;
   logic [TX_AW:0]   tx_count;
   logic [RX_AW:0]   rx_count;
   logic             tx_idle;

   // TX shifter
   logic [1:0]  tx_state_q;
   logic [31:0] tx_cnt_q, tx_div_q;
   logic [2:0]  tx_bit_q;
   logic [7:0]  tx_shift_q;
   logic        tx_end, tx_load;

   // RX shifter
   logic        rx_s1_q, rx_s2_q, rx_wait_hi_q;
   logic [1:0]  rx_state_q;
   logic [31:0] rx_cnt_q, rx_div_q;
   logic [2:0]  rx_bit_q;
   logic [7:0]  rx_shift_q;
   logic        rx_end, rx_half, rx_sample, rx_push, set_overrun, set_frame_err;

   logic unused_addr;
   assign unused_addr = ^mem_addr[1:0];

   assign off      = {mem_addr[3:2], 2'b00};
   assign sel      = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign is_wr    = |mem_wstrb;
   // A DATA write into a full TX FIFO is held off until the shifter takes a byte
   assign tx_stall = is_wr && (off == OFF_DATA) && tx_full;
   assign acc      = sel && !ready_q && !tx_stall;
   assign wr_div   = acc && is_wr && (off == OFF_DIV);
   assign tx_push  = acc && is_wr && (off == OFF_DATA) && mem_wstrb[0];
   assign rx_pop   = acc && !is_wr && (off == OFF_DATA) && !rx_empty;
   assign w1c      = acc && is_wr && (off == OFF_STATUS) && mem_wstrb[0];

   assign mem_ready = ready_q;
   assign mem_rdata = rdata_q;
   assign tx_idle   = tx_empty && (tx_state_q == FS_IDLE);

   always_comb begin
      status                = 32'h0;
      status[ST_TX_FULL]    = tx_full;
      status[ST_TX_IDLE]    = tx_idle;
      status[ST_RX_VALID]   = !rx_empty;
      status[ST_RX_OVERRUN] = overrun_q;
      status[ST_FRAME_ERR]  = frame_err_q;
      status[23:16]         = 8'(tx_count);
      status[31:24]         = 8'(rx_count);
   end

   // Read data mux, captured at accept time
   always_comb begin
      rd_val = 32'h0;
      case (off)
         OFF_DIV:    rd_val = div_q;
         OFF_DATA:   rd_val = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_rdata};
         OFF_STATUS: rd_val = status;
         OFF_IRQEN:  rd_val = irqen_rd;
         default:    rd_val = 32'h0;
      endcase
   end

   // One-cycle ready pulse; read data is zero outside the pulse
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_q <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         ready_q <= acc;
         rdata_q <= (acc && !is_wr) ? rd_val : 32'h0;
      end
   end

   // DIV register with byte strobes
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_q <= DIV_RESET;
      end else if (wr_div) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_wstrb[i]) div_q[8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   // Sticky error flags; a new error wins over a same-cycle clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         overrun_q   <= (overrun_q & ~(w1c & mem_wdata[ST_RX_OVERRUN])) | set_overrun;
         frame_err_q <= (frame_err_q & ~(w1c & mem_wdata[ST_FRAME_ERR])) | set_frame_err;
      end
   end

   soc_fifo_sync #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (tx_push),
      .wdata  (mem_wdata[7:0]),
      .pop    (tx_load),
      .rdata  (tx_rdata),
      .full   (tx_full),
      .empty  (tx_empty),
      .count  (tx_count)
   );

   soc_fifo_sync #(
      .WIDTH (8),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (rx_push),
      .wdata  (rx_shift_q),
      .pop    (rx_pop),
      .rdata  (rx_rdata),
      .full   (rx_full),
      .empty  (rx_empty),
      .count  (rx_count)
   );

   // ---------------- TX ----------------
   assign tx_end  = (tx_cnt_q == tx_div_q - 32'd1);
   // Load from idle, or straight out of the stop bit so frames run back-to-back
   assign tx_load = !tx_empty &&
                    ((tx_state_q == FS_IDLE) || ((tx_state_q == FS_STOP) && tx_end));

   // TX frame sequencer
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tx_state_q <= FS_IDLE;
         tx_cnt_q   <= 32'h0;
         tx_div_q   <= MIN_DIV;
         tx_bit_q   <= 3'd0;
         tx_shift_q <= 8'h00;
      end else if (tx_load) begin
         tx_shift_q <= tx_rdata;
         tx_div_q   <= eff_div(div_q);
         tx_cnt_q   <= 32'h0;
         tx_state_q <= FS_START;
      end else begin
         case (tx_state_q)
            FS_START: begin
               tx_cnt_q <= tx_end ? 32'h0 : tx_cnt_q + 32'd1;
               if (tx_end) begin
                  tx_bit_q   <= 3'd0;
                  tx_state_q <= FS_DATA;
               end
            end
            FS_DATA: begin
               tx_cnt_q <= tx_end ? 32'h0 : tx_cnt_q + 32'd1;
               if (tx_end) begin
                  tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                  tx_bit_q   <= tx_bit_q + 3'd1;
                  if (tx_bit_q == 3'd7) tx_state_q <= FS_STOP;
               end
            end
            FS_STOP: begin
               tx_cnt_q <= tx_cnt_q + 32'd1;
               if (tx_end) tx_state_q <= FS_IDLE;
            end
            default: tx_state_q <= FS_IDLE;
         endcase
      end
   end

   // Line level decoded from the frame state; idle and stop are high
   always_comb begin
      case (tx_state_q)
         FS_START: uart_tx = 1'b0;
         FS_DATA:  uart_tx = tx_shift_q[0];
         default:  uart_tx = 1'b1;
      endcase
   end

   // ---------------- RX ----------------
   // Two-flop synchroniser for the asynchronous line
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
      end else begin
         rx_s1_q <= uart_rx;
         rx_s2_q <= rx_s1_q;
      end
   end

   assign rx_end        = (rx_cnt_q == rx_div_q - 32'd1);
   assign rx_half       = (rx_cnt_q == (rx_div_q >> 1) - 32'd1);
   assign rx_sample     = (rx_state_q == FS_STOP) && rx_end;
   assign rx_push       = rx_sample && rx_s2_q;
   assign set_overrun   = rx_push && rx_full;
   assign set_frame_err = rx_sample && !rx_s2_q;

   // RX frame sequencer: start verified at half period, then sampled mid-bit
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_state_q   <= FS_IDLE;
         rx_cnt_q     <= 32'h0;
         rx_div_q     <= MIN_DIV;
         rx_bit_q     <= 3'd0;
         rx_shift_q   <= 8'h00;
         rx_wait_hi_q <= 1'b0;
      end else begin
         case (rx_state_q)
            FS_IDLE: begin
               if (rx_wait_hi_q) begin
                  // After a bad stop bit, ignore the line until it returns high
                  if (rx_s2_q) rx_wait_hi_q <= 1'b0;
               end else if (!rx_s2_q) begin
                  rx_div_q   <= eff_div(div_q);
                  rx_cnt_q   <= 32'h0;
                  rx_state_q <= FS_START;
               end
            end
            FS_START: begin
               if (rx_half) begin
                  rx_cnt_q   <= 32'h0;
                  rx_bit_q   <= 3'd0;
                  rx_state_q <= rx_s2_q ? FS_IDLE : FS_DATA;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 32'd1;
               end
            end
            FS_DATA: begin
               rx_cnt_q <= rx_end ? 32'h0 : rx_cnt_q + 32'd1;
               if (rx_end) begin
                  rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                  rx_bit_q   <= rx_bit_q + 3'd1;
                  if (rx_bit_q == 3'd7) rx_state_q <= FS_STOP;
               end
            end
            FS_STOP: begin
               rx_cnt_q <= rx_end ? 32'h0 : rx_cnt_q + 32'd1;
               if (rx_end) begin
                  rx_state_q <= FS_IDLE;
                  if (!rx_s2_q) rx_wait_hi_q <= 1'b1;
               end
            end
            default: rx_state_q <= FS_IDLE;
         endcase
      end
   end

   // ---------------- IRQ ----------------
`ifdef SOC_UART_IRQ_EN
   logic [2:0] irqen_q;
   logic       irq_q;
   logic [2:0] irq_src;

   assign irq_src[IE_RX_VALID] = !rx_empty;
   assign irq_src[IE_TX_IDLE]  = tx_idle;
   assign irq_src[IE_ERR]      = overrun_q | frame_err_q;
   assign irqen_rd             = {29'h0, irqen_q};
   assign irq                  = irq_q;

   // Enable register and registered level interrupt
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         irqen_q <= 3'b000;
         irq_q   <= 1'b0;
      end else begin
         if (acc && is_wr && (off == OFF_IRQEN) && mem_wstrb[0]) irqen_q <= mem_wdata[2:0];
         irq_q <= |(irqen_q & irq_src);
      end
   end
`else
   assign irqen_rd = 32'h0;
   assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_soc_uart_fifo.sv
// Self-checking bench for soc_uart_fifo: directed steps with random data,
// a queue-based reference model for the RX FIFO and a serial line decoder for TX.
module tb_soc_uart_fifo;

   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h0200_0010;
   localparam logic [3:0]  A_DIV = 4'h0, A_DATA = 4'h4, A_STAT = 4'h8, A_IEN = 4'hC;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic [3:0]  mem_wstrb = 4'h0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        uart_tx;
   logic        uart_rx = 1'b1;
   logic        irq;

   always #5 clk = ~clk;

   soc_uart_fifo #(
      .BASE_ADDR (BASE),
      .TX_DEPTH  (DEPTH),
      .RX_DEPTH  (DEPTH),
      .DIV_RESET (32'd104)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .uart_tx   (uart_tx),
      .uart_rx   (uart_rx),
      .irq       (irq)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state
   logic [7:0] rx_model[$];
   logic       m_ovr = 1'b0;
   logic       m_fe  = 1'b0;
   logic [7:0] sent[$];
   logic [7:0] mon_q[$];
   int         mon_div  = 16;
   int         mon_ferr = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic bus(input logic [3:0] off, input logic [31:0] wd, input logic [3:0] strb,
                      output logic [31:0] rdv, output int lat);
      logic got;
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = BASE + {28'h0, off};
      mem_wdata = wd;
      mem_wstrb = strb;
      lat = 0;
      got = 1'b0;
      rdv = 32'hDEAD_BEEF;
      while (!got && lat < 5000) begin
         @(negedge clk);
         lat++;
         if (mem_ready === 1'b1) begin
            got = 1'b1;
            rdv = mem_rdata;
         end
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL bus_timeout: observed no mem_ready after %0d cycles, expected a pulse", lat);
      end
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] wd, input logic [3:0] strb);
      logic [31:0] r;
      int lat;
      bus(off, wd, strb, r, lat);
   endtask

   task automatic rd(input logic [3:0] off, output logic [31:0] r);
      int lat;
      bus(off, 32'h0, 4'h0, r, lat);
   endtask

   // Expected STATUS when the transmitter is empty and idle
   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s = 32'h0000_0002;
      s[2]     = (rx_model.size() != 0);
      s[3]     = m_ovr;
      s[4]     = m_fe;
      s[31:24] = 8'(rx_model.size());
      return s;
   endfunction

   task automatic chk_status(input string tag);
      logic [31:0] s;
      rd(A_STAT, s);
      chk(tag, s, exp_status());
   endtask

   task automatic rd_data_chk(input string tag);
      logic [31:0] r, e;
      e = 32'hFFFF_FFFF;
      if (rx_model.size() != 0) e = {24'h0, rx_model.pop_front()};
      rd(A_DATA, r);
      chk(tag, r, e);
   endtask

   // Drive one serial frame on uart_rx and update the reference model
   task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int div);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rx = fr[i];
         repeat (div) @(negedge clk);
      end
      uart_rx = 1'b1;
      if (stop_bit) begin
         if (rx_model.size() < DEPTH) rx_model.push_back(b);
         else m_ovr = 1'b1;
      end else begin
         m_fe = 1'b1;
      end
   endtask

   task automatic wait_tx_idle(input string tag);
      logic [31:0] s;
      s = 32'h0;
      for (int k = 0; k < 3000 && s[1] !== 1'b1; k++) rd(A_STAT, s);
      chk(tag, {31'h0, s[1]}, 32'h1);
   endtask

   task automatic chk_mon(input string tag);
      chk({tag, "_count"}, 32'(mon_q.size()), 32'(sent.size()));
      for (int i = 0; i < sent.size() && i < mon_q.size(); i++)
         chk(tag, {24'h0, mon_q[i]}, {24'h0, sent[i]});
      mon_q.delete();
      sent.delete();
   endtask

   // Cycle-exact waveform check of one frame at a 16-clock bit period
   task automatic tx_wave(input logic [7:0] b);
      logic [31:0] r;
      int lat, f, bad;
      logic e;
      bus(A_DATA, {24'hABCDEF, b}, 4'h1, r, lat);
      chk("tx_write_lat", 32'(lat), 32'd1);
      f = -1;
      for (int j = 0; j < 4 && f < 0; j++) begin
         if (uart_tx === 1'b0) f = j;
         else @(negedge clk);
      end
      chk("tx_start_seen", {31'h0, (f >= 0)}, 32'h1);
      bad = 0;
      for (int k = 0; k < 170; k++) begin
         if (k < 16) e = 1'b0;
         else if (k < 144) e = b[(k - 16) / 16];
         else e = 1'b1;
         if (uart_tx !== e) bad++;
         @(negedge clk);
      end
      chk("tx_wave_bad_cycles", 32'(bad), 32'd0);
   endtask

   // Independent serial decoder on uart_tx
   initial begin : mon
      logic [7:0] mb;
      forever begin
         @(negedge clk);
         if (uart_tx === 1'b0) begin
            repeat (mon_div / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (mon_div) @(negedge clk);
               mb[i] = uart_tx;
            end
            repeat (mon_div) @(negedge clk);
            if (uart_tx !== 1'b1) mon_ferr++;
            else mon_q.push_back(mb);
         end
      end
   end

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: observed no completion, expected finish within 3 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [31:0] r, s;
      logic [7:0]  b, g;
      int lat, maxlat, dv, ev, n;

      #2 resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'h0, mem_ready}, 32'h0);
      chk("rst_rdata", mem_rdata, 32'h0);
      chk("rst_tx", {31'h0, uart_tx}, 32'h1);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ready_after", {31'h0, mem_ready}, 32'h0);

      chk_status("rst_status");
      rd(A_DIV, r);
      chk("rst_div", r, 32'd104);
      rd_data_chk("rst_data_empty");

      // DIV byte strobes: only byte 0 written
      wr(A_DIV, 32'hAABB_CC10, 4'b0001);
      rd(A_DIV, r);
      chk("div_strobe", r, 32'h0000_0010);

      // Frame shape at DIV=16
      tx_wave(8'h55);
      tx_wave(8'($urandom));
      mon_q.delete();

      // Fill TX FIFO, then one write that must stall until a slot frees
      maxlat = 0;
      for (int i = 0; i < 17; i++) begin
         b = 8'($urandom);
         sent.push_back(b);
         bus(A_DATA, {24'h0, b}, 4'h1, r, lat);
         if (lat > maxlat) maxlat = lat;
      end
      chk("tx_burst_lat", 32'(maxlat), 32'd1);
      rd(A_STAT, s);
      chk("tx_full_bit", {31'h0, s[0]}, 32'h1);
      chk("tx_count_full", {24'h0, s[23:16]}, 32'd16);
      b = 8'($urandom);
      sent.push_back(b);
      bus(A_DATA, {24'h0, b}, 4'h1, r, lat);
      chk("tx_stall_lat", {31'h0, (lat > 20 && lat < 200)}, 32'h1);
      wait_tx_idle("tx_burst_idle");
      chk_mon("tx_burst_byte");

      // Single received byte
      send_rx(8'hA3, 1'b1, 16);
      repeat (3) @(negedge clk);
      chk_status("rx_one_status");
      rd_data_chk("rx_one_data");
      rd_data_chk("rx_one_empty");

      // Overrun: 17 bytes into a 16-deep FIFO
      for (int i = 0; i < 17; i++) send_rx(8'($urandom), 1'b1, 16);
      repeat (3) @(negedge clk);
      chk_status("rx_ovr_status");
      for (int i = 0; i < 17; i++) rd_data_chk("rx_ovr_data");
      wr(A_STAT, 32'h0000_0008, 4'hF);
      m_ovr = 1'b0;
      chk_status("rx_ovr_cleared");

      // Bad stop bit, then a short low glitch
      g = 8'($urandom);
      send_rx(g, 1'b1, 16);
      send_rx(8'($urandom), 1'b0, 16);
      repeat (4) @(negedge clk);
      chk_status("rx_frame_err");
      uart_rx = 1'b0;
      repeat (6) @(negedge clk);
      uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      chk_status("rx_glitch_ignored");
      wr(A_STAT, 32'hFFFF_FFE7, 4'hF);
      chk_status("status_w1c_other_bits");
      wr(A_STAT, 32'h0000_0010, 4'hF);
      m_fe = 1'b0;
      chk_status("rx_fe_cleared");
      rd_data_chk("rx_fe_data");
      rd_data_chk("rx_fe_empty");

`ifdef SOC_UART_IRQ_EN
      wr(A_IEN, 32'h0000_0001, 4'hF);
      rd(A_IEN, r);
      chk("irqen_rw", r, 32'h1);
      chk("irq_quiet", {31'h0, irq}, 32'h0);
      send_rx(8'($urandom), 1'b1, 16);
      repeat (3) @(negedge clk);
      chk("irq_rx_set", {31'h0, irq}, 32'h1);
      rd_data_chk("irq_data");
      repeat (3) @(negedge clk);
      chk("irq_rx_clear", {31'h0, irq}, 32'h0);
`else
      wr(A_IEN, 32'h0000_0007, 4'hF);
      rd(A_IEN, r);
      chk("irqen_absent", r, 32'h0);
      send_rx(8'($urandom), 1'b1, 16);
      repeat (3) @(negedge clk);
      chk("irq_tied_low", {31'h0, irq}, 32'h0);
      rd_data_chk("irq_data");
`endif

      // Random rounds with varying DIV, TX and RX overlapping; round 0 hits the minimum period
      for (int rnd = 0; rnd < 5; rnd++) begin
         dv = (rnd == 0) ? 1 : int'($urandom_range(4, 20));
         ev = (dv < 4) ? 4 : dv;
         wr(A_DIV, 32'(dv), 4'hF);
         rd(A_DIV, r);
         chk("rnd_div", r, 32'(dv));
         mon_div = ev;
         n = int'($urandom_range(1, 4));
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            wr(A_DATA, {24'h0, b}, 4'h1);
         end
         n = int'($urandom_range(1, 3));
         for (int i = 0; i < n; i++) send_rx(8'($urandom), 1'b1, ev);
         wait_tx_idle("rnd_tx_idle");
         chk_mon("rnd_tx_byte");
         chk_status("rnd_status");
         for (int i = 0; i <= n; i++) rd_data_chk("rnd_rx_data");
      end
      chk("tx_monitor_stop_errors", 32'(mon_ferr), 32'd0);

      // Asynchronous reset in the middle of a frame of zeros
      mon_div = 16;
      wr(A_DIV, 32'd16, 4'hF);
      wr(A_DATA, 32'h0, 4'h1);
      repeat (40) @(negedge clk);
      chk("pre_reset_tx_low", {31'h0, uart_tx}, 32'h0);
      #2 resetn = 1'b0;
      #1;
      chk("reset_tx_high", {31'h0, uart_tx}, 32'h1);
      chk("reset_ready_low", {31'h0, mem_ready}, 32'h0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      rx_model.delete();
      m_ovr = 1'b0;
      m_fe  = 1'b0;
      chk_status("post_reset_status");
      rd(A_DIV, r);
      chk("post_reset_div", r, 32'd104);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
